pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CYC_W, default 6: width of the multi-cycle latency field.
REQ-002 Parameter WDT_LIMIT, default 200: number of consecutive stalled cycles that trips the watchdog.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port stallreq_id_i, input, 1: ID-stage stall request (load-use / operand hazard).
REQ-006 Port stallreq_ex_i, input, 1: EX-stage external stall request.
REQ-007 Port ex_multi_start_i, input, 1: EX starts a multi-cycle operation this cycle.
REQ-008 Port ex_multi_cycles_i, input, CYC_W: busy length N of the started operation.
REQ-009 Port flush_i, input, 1: pipeline flush; aborts any multi-cycle operation.
REQ-010 Port stall_o, output, 6: stall vector; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-011 Port ex_busy_o, output, 1: FSM in BUSY.
REQ-012 Port ex_done_o, output, 1: one-cycle pulse; multi-cycle result valid.
REQ-013 Port timeout_o, output, 1: sticky watchdog flag.

Function
REQ-014 FSM states IDLE, BUSY, DONE; down-counter cnt, CYC_W bits.
REQ-015 IDLE with ex_multi_start_i=1: load cnt=N (N=0 treated as 1), next state BUSY.
REQ-016 ex_multi_start_i ignored in BUSY and DONE.
REQ-017 BUSY: cnt decrements each cycle; when cnt==1, next state DONE.
REQ-018 DONE: ex_done_o=1 for exactly that cycle; next state IDLE.
REQ-019 stall_o combinational: flush_i=1 -> 6'b000000; else BUSY, stallreq_ex_i, or (IDLE and ex_multi_start_i) -> 6'b001111; else stallreq_id_i -> 6'b000111; else 6'b000000.
REQ-020 EX stall pattern has priority over ID; simultaneous requests yield 6'b001111.
REQ-021 A start with length N stalls exactly N+1 cycles (start cycle plus N BUSY cycles); DONE is unstalled.
REQ-022 flush_i has highest priority: next state IDLE, cnt cleared, no ex_done_o pulse, and any coincident start is ignored.
REQ-023 ex_busy_o=1 iff state==BUSY; ex_done_o=1 iff state==DONE.

Reset
REQ-024 rst=1 asynchronously forces state IDLE, cnt=0, watchdog counter 0, timeout_o=0.
REQ-025 While rst=1: stall_o=6'b000000, ex_busy_o=0, ex_done_o=0, regardless of inputs.
REQ-026 Reset asserted mid-BUSY aborts the operation with no ex_done_o pulse.

Configuration
REQ-027 Macro PIPE_CTRL_STALL_WATCHDOG_EN compiles in the watchdog.
REQ-028 With macro: an 8-bit counter increments each cycle stall_o!=0 and clears when stall_o==0. On reaching WDT_LIMIT, timeout_o sets (sticky until reset), the FSM is forced to IDLE, cnt is cleared, and the counter clears.
REQ-029 Without macro: no watchdog logic; timeout_o tied 0; stalls are unbounded.

Verification
REQ-030 Reset, then idle inputs -> stall_o=000000, ex_busy_o=0, ex_done_o=0, timeout_o=0.
REQ-031 stallreq_id_i=1 for 1 cycle -> stall_o=000111 that cycle only; FSM stays IDLE.
REQ-032 Start with N=4 at cycle T -> stall_o=001111 for cycles T..T+4, ex_done_o=1 at T+5, IDLE at T+6; a second start at T+2 is ignored.
REQ-033 Start N=10, then flush_i at the 3rd BUSY cycle -> stall_o=0 that cycle, IDLE next cycle, no ex_done_o.
REQ-034 stallreq_id_i and stallreq_ex_i both 1 -> stall_o=001111. Start with N=0 -> one BUSY cycle, then DONE.
REQ-035 Watchdog build, WDT_LIMIT=200, stallreq_ex_i held 1 -> timeout_o rises after 200 stalled cycles and stays 1 until rst. Non-watchdog build -> timeout_o stays 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller with a multi-cycle EX busy FSM.
// Optional stall watchdog compiled in by PIPE_CTRL_STALL_WATCHDOG_EN.
module pipe_ctrl #(
  parameter int CYC_W     = 6,
  parameter int WDT_LIMIT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             ex_multi_start_i,
  input  logic [CYC_W-1:0] ex_multi_cycles_i,
  input  logic             flush_i,
  output logic [5:0]       stall_o,
  output logic             ex_busy_o,
  output logic             ex_done_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CYC_W-1:0] CNT_ONE = CYC_W'(1);
  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CYC_W-1:0] r_cnt;
  logic [CYC_W-1:0] w_cnt_nx;
  logic             w_wdt_trip;
  logic             w_stalled;

  // State and latency counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next state: flush and watchdog trip override any FSM progress
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (ex_multi_start_i) begin
          w_state_nx = S_BUSY;
          w_cnt_nx   = (ex_multi_cycles_i == '0) ?
                       CNT_ONE : ex_multi_cycles_i;
        end
      end
      S_BUSY: begin
        w_cnt_nx = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
    if (flush_i || w_wdt_trip) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
    end
  end

  // Outputs: EX pattern wins over ID, flush and reset silence everything
  always_comb begin
    stall_o   = '0;
    ex_busy_o = 1'b0;
    ex_done_o = 1'b0;
    if (!rst) begin
      ex_busy_o = (r_state == S_BUSY);
      ex_done_o = (r_state == S_DONE);
      if (flush_i) begin
        stall_o = '0;
      end else if ((r_state == S_BUSY) || stallreq_ex_i ||
                   ((r_state == S_IDLE) && ex_multi_start_i)) begin
        stall_o = STALL_EX;
      end else if (stallreq_id_i) begin
        stall_o = STALL_ID;
      end
    end
  end

  assign w_stalled = (stall_o != 6'b000000);

`ifdef PIPE_CTRL_STALL_WATCHDOG_EN
  localparam logic [7:0] WDT_LAST = 8'(WDT_LIMIT - 1);

  logic [7:0] r_wdt;
  logic       r_timeout;

  assign w_wdt_trip = w_stalled && (r_wdt == WDT_LAST);
  assign timeout_o  = r_timeout;

  // Consecutive-stall counter with sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdt     <= '0;
      r_timeout <= 1'b0;
    end else if (w_wdt_trip) begin
      r_wdt     <= '0;
      r_timeout <= 1'b1;
    end else if (w_stalled) begin
      r_wdt     <= r_wdt + 8'd1;
    end else begin
      r_wdt     <= '0;
    end
  end
`else
  logic w_unused;
  assign w_unused   = w_stalled;
  assign w_wdt_trip = 1'b0;
  assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus random stimulus
// checked against a cycle-schedule reference model.
module tb_pipe_ctrl;

  localparam int CYC_W     = 6;
  localparam int WDT_LIMIT = 200;
`ifdef PIPE_CTRL_STALL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id  = 1'b0;
  logic             ex  = 1'b0;
  logic             st  = 1'b0;
  logic [CYC_W-1:0] n   = '0;
  logic             fl  = 1'b0;
  logic [5:0]       stall;
  logic             busy;
  logic             done;
  logic             tmo;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(
    .CYC_W     (CYC_W),
    .WDT_LIMIT (WDT_LIMIT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_id_i     (id),
    .stallreq_ex_i     (ex),
    .ex_multi_start_i  (st),
    .ex_multi_cycles_i (n),
    .flush_i           (fl),
    .stall_o           (stall),
    .ex_busy_o         (busy),
    .ex_done_o         (done),
    .timeout_o         (tmo)
  );

  always #5 clk = ~clk;

  // reference model: an operation is a scheduled window of cycles
  int         m_cyc;
  int         m_start;
  int         m_end;
  int         m_wrun;
  bit         m_to;
  logic [5:0] e_stall;
  logic       e_busy;
  logic       e_done;

  task automatic model_reset();
    m_cyc = 0; m_start = 0; m_end = -1;
    m_wrun = 0; m_to = 1'b0;
  endtask

  task automatic model_eval();
    bit b, d, idl;
    b   = (m_end >= 0) && (m_cyc > m_start) && (m_cyc < m_end);
    d   = (m_end >= 0) && (m_cyc == m_end);
    idl = !b && !d;
    if (fl) e_stall = 6'h00;
    else if (b || ex || (idl && st)) e_stall = 6'h0F;
    else if (id) e_stall = 6'h07;
    else e_stall = 6'h00;
    e_busy = b;
    e_done = d;
  endtask

  task automatic model_commit();
    int len;
    if (fl) begin
      m_end = -1;
    end else if (!e_busy && !e_done && st) begin
      len = (int'(n) == 0) ? 1 : int'(n);
      m_start = m_cyc;
      m_end = m_cyc + len + 1;
    end
    if (WD) begin
      if (e_stall != 6'h00) begin
        m_wrun++;
        if (m_wrun == WDT_LIMIT) begin
          m_to = 1'b1; m_end = -1; m_wrun = 0;
        end
      end else begin
        m_wrun = 0;
      end
    end
    m_cyc++;
  endtask

  task automatic set_in(input logic i_id, input logic i_ex,
                        input logic i_st, input int i_n,
                        input logic i_fl);
    id = i_id; ex = i_ex; st = i_st;
    n = CYC_W'(i_n); fl = i_fl;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    next_cyc();
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 5, 0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 6'h00) begin
      errors++; $display("FAIL rst_stall: got %h need 00", stall);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tmo !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: busy=%b done=%b tmo=%b need 000",
               busy, done, tmo);
    end
    set_in(0, 0, 0, 0, 0);
    rst = 1'b0;
    next_cyc();
    @(negedge clk);
    checks++;
    if ({stall, busy, done, tmo} !== 9'h000) begin
      errors++;
      $display("FAIL idle_after_rst: got %h need 000",
               {stall, busy, done, tmo});
    end
    next_cyc();
  endtask

  task automatic test_id_stall();
    for (int k = 0; k < 3; k++) begin
      set_in(k == 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (stall !== ((k == 0) ? 6'h07 : 6'h00) || busy !== 1'b0) begin
        errors++;
        $display("FAIL id_stall k=%0d: stall=%h busy=%b", k, stall, busy);
      end
      next_cyc();
    end
  endtask

  task automatic test_multi();
    for (int k = 0; k < 8; k++) begin
      set_in(0, 0, (k == 0) || (k == 2), (k == 2) ? 9 : 4, 0);
      @(negedge clk);
      checks++;
      if (stall !== ((k <= 4) ? 6'h0F : 6'h00)) begin
        errors++;
        $display("FAIL multi_stall k=%0d: got %h", k, stall);
      end
      checks++;
      if (busy !== (k >= 1 && k <= 4) || done !== (k == 5)) begin
        errors++;
        $display("FAIL multi_flags k=%0d: busy=%b done=%b", k, busy, done);
      end
      next_cyc();
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 17; k++) begin
      set_in(0, 0, (k == 0) || (k == 15), 10,
             (k == 3) || (k == 15));
      @(negedge clk);
      checks++;
      if (stall !== ((k <= 2) ? 6'h0F : 6'h00)) begin
        errors++;
        $display("FAIL flush_stall k=%0d: got %h", k, stall);
      end
      checks++;
      if (busy !== (k >= 1 && k <= 3) || done !== 1'b0) begin
        errors++;
        $display("FAIL flush_flags k=%0d: busy=%b done=%b", k, busy, done);
      end
      next_cyc();
    end
  endtask

  task automatic test_both_and_n0();
    for (int k = 0; k < 5; k++) begin
      set_in(k == 0, k == 0, k == 1, 0, 0);
      @(negedge clk);
      checks++;
      if (stall !== ((k <= 2) ? 6'h0F : 6'h00)) begin
        errors++;
        $display("FAIL both_n0_stall k=%0d: got %h", k, stall);
      end
      checks++;
      if (busy !== (k == 2) || done !== (k == 3)) begin
        errors++;
        $display("FAIL n0_flags k=%0d: busy=%b done=%b", k, busy, done);
      end
      next_cyc();
    end
  endtask

  task automatic test_rst_mid_busy();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, k == 0, 8, 0);
      next_cyc();
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL pre_rst_busy: got %b need 1", busy);
    end
    set_in(0, 1, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || stall !== 6'h00) begin
      errors++;
      $display("FAIL async_rst: busy=%b stall=%h need 0/00", busy, stall);
    end
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    next_cyc();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL post_rst k=%0d: busy=%b done=%b", k, busy, done);
      end
      next_cyc();
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 1; i <= WDT_LIMIT + 5; i++) begin
      set_in(0, 1, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (tmo !== (WD && (i > WDT_LIMIT))) begin
        errors++;
        $display("FAIL wdt cyc=%0d: got %b need %b",
                 i, tmo, WD && (i > WDT_LIMIT));
      end
      next_cyc();
    end
    set_in(0, 0, 0, 0, 0);
    next_cyc();
    @(negedge clk);
    checks++;
    if (tmo !== WD) begin
      errors++; $display("FAIL wdt_sticky: got %b need %b", tmo, WD);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (tmo !== 1'b0) begin
      errors++; $display("FAIL wdt_rst_clear: got %b need 0", tmo);
    end
    next_cyc();
  endtask

  task automatic test_random();
    int shown;
    shown = 0;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      set_in(($urandom % 4) == 0, ($urandom % 8) == 0,
             ($urandom % 4) == 0,
             (($urandom % 16) == 0) ? int'($urandom % 64)
                                    : int'($urandom_range(0, 6)),
             ($urandom % 20) == 0);
      @(negedge clk);
      model_eval();
      checks++;
      if (stall !== e_stall) begin
        errors++;
        if (shown++ < 20)
          $display("FAIL rnd_stall c=%0d: got %h need %h", c, stall, e_stall);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        if (shown++ < 20)
          $display("FAIL rnd_busy c=%0d: got %b need %b", c, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        errors++;
        if (shown++ < 20)
          $display("FAIL rnd_done c=%0d: got %b need %b", c, done, e_done);
      end
      checks++;
      if (tmo !== m_to) begin
        errors++;
        if (shown++ < 20)
          $display("FAIL rnd_tmo c=%0d: got %b need %b", c, tmo, m_to);
      end
      model_commit();
      next_cyc();
    end
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_multi();
    test_flush();
    test_both_and_n0();
    test_rst_mid_busy();
    test_watchdog();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
